// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB has priority, long-latency results
// queue in a FIFO and drain into idle slots; also tracks per-register busy bits and starvation.
module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    input  logic        issue_valid,
    input  logic [4:0]  issue_waddr,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy,
    output logic        starve
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   busy_q, busy_d;
    logic [7:0]    starve_cnt_q, starve_cnt_d;
    logic          starve_q, starve_d;

    logic pipe_take;
    logic fifo_empty;
    logic push;
    logic pop;

    assign pipe_take  = pipe_wen && (pipe_waddr != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign lu_ready   = (count_q < FULL_C);
    assign push       = lu_valid && lu_ready;
    assign pop        = !pipe_take && !fifo_empty;

    assign busy   = busy_q;
    assign starve = starve_q;

    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (pipe_take) begin
            rf_wen   = 1'b1;
            rf_waddr = pipe_waddr;
            rf_wdata = pipe_wdata;
        end else if (pop) begin
            // A queued result aimed at r0 is drained without touching the register file
            rf_wen   = (addr_mem[rd_ptr_q] != 5'd0);
            rf_waddr = addr_mem[rd_ptr_q];
            rf_wdata = data_mem[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Set is applied after clear so a same-edge issue keeps the bit high
    always_comb begin
        busy_d = busy_q;
        if (pop) busy_d[addr_mem[rd_ptr_q]] = 1'b0;
        if (issue_valid && (issue_waddr != 5'd0)) busy_d[issue_waddr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        starve_cnt_d = 8'd0;
        if (!fifo_empty && pipe_take) begin
            starve_cnt_d = (starve_cnt_q == 8'hFF) ? 8'hFF : starve_cnt_q + 8'd1;
        end
        starve_d = (starve_cnt_d >= 8'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= lu_waddr;
            data_mem[wr_ptr_q] <= lu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            busy_q       <= 32'd0;
            starve_cnt_q <= 8'd0;
            starve_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

endmodule
